// File: rtl/hs32_wb_arbiter.sv
// hs32_wb_arbiter: writeback arbiter and register scoreboard for the HS32 core.
// Grants one of the ALU / LSU writeback requests per cycle, registers the winner
// onto the register file's single write port, and tracks per-register busy bits.
// Optional feature macro: HS32_WB_ARBITER_RR_EN (round-robin arbitration instead
// of fixed LSU priority).
module hs32_wb_arbiter #(
    parameter int unsigned RESET = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [3:0]  alu_addr_i,
    input  logic        alu_bank_i,
    input  logic        alu_lo_i,
    input  logic [31:0] alu_data_i,

    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [3:0]  lsu_addr_i,
    input  logic        lsu_bank_i,
    input  logic        lsu_lo_i,
    input  logic [31:0] lsu_data_i,

    input  logic        sb_set_i,
    input  logic [3:0]  sb_addr_i,
    input  logic        sb_bank_i,
    output logic [23:0] busy_o,

    output logic [3:0]  wp_addr_o,
    output logic [31:0] wp_data_o,
    output logic        wp_we1_o,
    output logic        wp_we2_o,
    output logic        wp_wel_o,
    output logic        err_o
);

    // Busy-vector bit for (addr, bank): bank 0 -> [15:0], bank 1 -> [23:16] by addr[2:0].
    function automatic logic [4:0] sb_index(input logic [3:0] addr, input logic bank);
        if (bank) begin
            sb_index = {2'b10, addr[2:0]};
        end else begin
            sb_index = {1'b0, addr};
        end
    endfunction

    logic        alu_grant;
    logic        lsu_grant;
    logic        accept;
    logic [3:0]  sel_addr;
    logic        sel_bank;
    logic        sel_lo;
    logic [31:0] sel_data;

    logic        we1_q;
    logic        we2_q;
    logic        wel_q;
    logic [3:0]  addr_q;
    logic [31:0] data_q;

    logic [23:0] busy_q;
    logic [23:0] busy_d;
    logic [23:0] clr_mask;
    logic [23:0] set_mask;
    logic        err_q;
    logic        err_d;

`ifdef HS32_WB_ARBITER_RR_EN
    typedef enum logic {PrefAlu, PrefLsu} rr_state_e;
    rr_state_e rr_q;
    rr_state_e rr_d;

    // Round-robin pointer register; resets to prefer the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= PrefAlu;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Grant decode and pointer update: contention goes to the preferred side, which
    // then hands preference to the other; a lone requester leaves the pointer alone.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        rr_d      = rr_q;
        if (!reset) begin
            if (alu_valid_i && lsu_valid_i) begin
                if (rr_q == PrefAlu) begin
                    alu_grant = 1'b1;
                    rr_d      = PrefLsu;
                end else begin
                    lsu_grant = 1'b1;
                    rr_d      = PrefAlu;
                end
            end else begin
                alu_grant = alu_valid_i;
                lsu_grant = lsu_valid_i;
            end
        end
    end
`else
    // Fixed priority grant: the LSU always wins, so the ALU can starve.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset) begin
            lsu_grant = lsu_valid_i;
            alu_grant = alu_valid_i && !lsu_valid_i;
        end
    end
`endif

    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;
    assign accept      = alu_grant || lsu_grant;

    // Winner mux feeding the write-port registers.
    always_comb begin
        sel_addr = alu_addr_i;
        sel_bank = alu_bank_i;
        sel_lo   = alu_lo_i;
        sel_data = alu_data_i;
        if (lsu_grant) begin
            sel_addr = lsu_addr_i;
            sel_bank = lsu_bank_i;
            sel_lo   = lsu_lo_i;
            sel_data = lsu_data_i;
        end
    end

    // Write-port registers: enables pulse for one cycle per accept, payload holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            we1_q <= 1'b0;
            we2_q <= 1'b0;
            if (RESET != 0) begin
                wel_q  <= 1'b0;
                addr_q <= 4'd0;
                data_q <= 32'd0;
            end
        end else begin
            we1_q <= accept && !sel_bank;
            we2_q <= accept && sel_bank;
            if (accept) begin
                wel_q  <= sel_lo;
                addr_q <= sel_addr;
                data_q <= sel_data;
            end
        end
    end

    // Scoreboard next state: clear the bit being written this edge, then apply the
    // issue-side set so a newer instruction's pending mark survives a same-edge clear.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (we1_q || we2_q) begin
            clr_mask = 24'd1 << sb_index(addr_q, we2_q);
        end
        if (sb_set_i) begin
            set_mask = 24'd1 << sb_index(sb_addr_i, sb_bank_i);
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
        err_d  = err_q || (|(busy_q & set_mask & ~clr_mask));
    end

    // Scoreboard state; with RESET=0 the busy bits survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET != 0) begin
                busy_q <= '0;
            end
        end else begin
            busy_q <= busy_d;
        end
    end

    // Sticky double-set error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Enables are masked during reset so an in-flight write never reaches the file.
    assign wp_we1_o  = we1_q && !reset;
    assign wp_we2_o  = we2_q && !reset;
    assign wp_wel_o  = wel_q;
    assign wp_addr_o = addr_q;
    assign wp_data_o = data_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_hs32_wb_arbiter.sv
// Self-checking bench for hs32_wb_arbiter: directed steps, expected write-port
// transactions queued when a grant is predicted and compared when the port fires.
module tb_hs32_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_i, alu_ready_o, alu_bank_i, alu_lo_i;
    logic [3:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i, lsu_ready_o, lsu_bank_i, lsu_lo_i;
    logic [3:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        sb_set_i, sb_bank_i;
    logic [3:0]  sb_addr_i;
    logic [23:0] busy_o;
    logic [3:0]  wp_addr_o;
    logic [31:0] wp_data_o;
    logic        wp_we1_o, wp_we2_o, wp_wel_o, err_o;

    int errors = 0;
    int checks = 0;
    logic [38:0] exp_q[$];
    logic m_pref_lsu = 1'b0;

    hs32_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_addr_i(alu_addr_i),
        .alu_bank_i(alu_bank_i), .alu_lo_i(alu_lo_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_addr_i(lsu_addr_i),
        .lsu_bank_i(lsu_bank_i), .lsu_lo_i(lsu_lo_i), .lsu_data_i(lsu_data_i),
        .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i), .sb_bank_i(sb_bank_i), .busy_o(busy_o),
        .wp_addr_o(wp_addr_o), .wp_data_o(wp_data_o), .wp_we1_o(wp_we1_o),
        .wp_we2_o(wp_we2_o), .wp_wel_o(wp_wel_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and retire any write-port transaction.
    task automatic tick();
        logic [38:0] act;
        logic [38:0] exp;
        @(posedge clk);
        #1;
        act = {wp_we2_o, wp_we1_o, wp_wel_o, wp_addr_o, wp_data_o};
        if (wp_we1_o || wp_we2_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(act), 64'd0);
            end else begin
                exp = exp_q.pop_front();
                check("wp_port", 64'(act), 64'(exp));
            end
        end
    endtask

    // Predict the grant for the currently driven valids, check readies, queue the write.
    task automatic arb_cycle(output logic g_alu, output logic g_lsu);
        #1;
        g_alu = 1'b0;
        g_lsu = 1'b0;
`ifdef HS32_WB_ARBITER_RR_EN
        if (alu_valid_i && lsu_valid_i) begin
            if (m_pref_lsu) g_lsu = 1'b1;
            else g_alu = 1'b1;
            m_pref_lsu = !m_pref_lsu;
        end else begin
            g_alu = alu_valid_i;
            g_lsu = lsu_valid_i;
        end
`else
        g_lsu = lsu_valid_i;
        g_alu = alu_valid_i && !lsu_valid_i;
`endif
        check("alu_ready", 64'(alu_ready_o), 64'(g_alu));
        check("lsu_ready", 64'(lsu_ready_o), 64'(g_lsu));
        if (g_alu) exp_q.push_back({alu_bank_i, !alu_bank_i, alu_lo_i, alu_addr_i, alu_data_i});
        if (g_lsu) exp_q.push_back({lsu_bank_i, !lsu_bank_i, lsu_lo_i, lsu_addr_i, lsu_data_i});
        tick();
    endtask

    initial begin
        logic ga, gl;
        int   n_alu, n_lsu;
        logic [3:0] order;

        reset = 1'b1;
        alu_valid_i = 0; alu_addr_i = 0; alu_bank_i = 0; alu_lo_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_addr_i = 0; lsu_bank_i = 0; lsu_lo_i = 0; lsu_data_i = 0;
        sb_set_i = 0; sb_addr_i = 0; sb_bank_i = 0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_we1", 64'(wp_we1_o), 64'd0);
        check("rst_we2", 64'(wp_we2_o), 64'd0);
        check("rst_wel", 64'(wp_wel_o), 64'd0);
        check("rst_addr", 64'(wp_addr_o), 64'd0);
        check("rst_data", 64'(wp_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);

        // ALU write to bank 0 r3 with low half enabled.
        alu_valid_i = 1; alu_addr_i = 4'd3; alu_bank_i = 0; alu_lo_i = 1;
        alu_data_i = 32'hDEADBEEF;
        arb_cycle(ga, gl);
        alu_valid_i = 0;
        tick();
        check("idle_we1", 64'(wp_we1_o), 64'd0);
        check("hold_addr", 64'(wp_addr_o), 64'd3);
        check("hold_data", 64'(wp_data_o), 64'hDEADBEEF);

        // Mark bank 1 r5 pending, then clear it through an LSU write.
        sb_set_i = 1; sb_addr_i = 4'd5; sb_bank_i = 1;
        tick();
        sb_set_i = 0;
        check("busy_b1r5_set", 64'(busy_o[21]), 64'd1);
        lsu_valid_i = 1; lsu_addr_i = 4'd5; lsu_bank_i = 1; lsu_lo_i = 0;
        lsu_data_i = 32'h12345678;
        arb_cycle(ga, gl);
        lsu_valid_i = 0;
        check("busy_b1r5_still", 64'(busy_o[21]), 64'd1);
        tick();
        check("busy_b1r5_clr", 64'(busy_o), 64'd0);

        // Contention for four cycles.
        n_alu = 0; n_lsu = 0; order = 4'b0000;
        alu_valid_i = 1; alu_addr_i = 4'd10; alu_bank_i = 0; alu_lo_i = 1;
        alu_data_i = 32'hA0000000;
        lsu_valid_i = 1; lsu_addr_i = 4'd11; lsu_bank_i = 0; lsu_lo_i = 0;
        lsu_data_i = 32'hB0000000;
        for (int i = 0; i < 4; i++) begin
            arb_cycle(ga, gl);
            if (ga) begin
                n_alu++;
                order[i] = 1'b1;
                alu_data_i = alu_data_i + 32'd1;
            end
            if (gl) begin
                n_lsu++;
                lsu_data_i = lsu_data_i + 32'd1;
                lsu_lo_i = !lsu_lo_i;
            end
        end
        alu_valid_i = 0;
        lsu_valid_i = 0;
`ifdef HS32_WB_ARBITER_RR_EN
        check("alu_grants", 64'(n_alu), 64'd2);
        check("lsu_grants", 64'(n_lsu), 64'd2);
        check("grant_order", 64'(order), 64'b0101);
`else
        check("alu_grants", 64'(n_alu), 64'd0);
        check("lsu_grants", 64'(n_lsu), 64'd4);
        check("grant_order", 64'(order), 64'b0000);
`endif
        tick();
        check("busy_after_contention", 64'(busy_o), 64'd0);

        // Same-edge set and clear of bank 0 r7: set wins, no error.
        sb_set_i = 1; sb_addr_i = 4'd7; sb_bank_i = 0;
        tick();
        sb_set_i = 0;
        check("busy_r7_set", 64'(busy_o[7]), 64'd1);
        alu_valid_i = 1; alu_addr_i = 4'd7; alu_bank_i = 0; alu_lo_i = 0;
        alu_data_i = 32'h00000777;
        arb_cycle(ga, gl);
        alu_valid_i = 0;
        sb_set_i = 1; sb_addr_i = 4'd7; sb_bank_i = 0;
        tick();
        sb_set_i = 0;
        check("busy_r7_setwins", 64'(busy_o[7]), 64'd1);
        check("err_r7", 64'(err_o), 64'd0);

        // Double set of bank 0 r2 raises the sticky error.
        sb_set_i = 1; sb_addr_i = 4'd2; sb_bank_i = 0;
        tick();
        check("err_first_set", 64'(err_o), 64'd0);
        check("busy_r2", 64'(busy_o[2]), 64'd1);
        tick();
        sb_set_i = 0;
        check("err_double_set", 64'(err_o), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("err_sticky", 64'(err_o), 64'd1);
        reset = 1;
        tick();
        reset = 0;
        m_pref_lsu = 1'b0;
        check("err_after_reset", 64'(err_o), 64'd0);
        check("busy_after_reset", 64'(busy_o), 64'd0);

        // Reset in the cycle after an accept drops the in-flight write.
        sb_set_i = 1; sb_addr_i = 4'd9; sb_bank_i = 0;
        tick();
        sb_set_i = 0;
        check("busy_r9", 64'(busy_o[9]), 64'd1);
        alu_valid_i = 1; alu_addr_i = 4'd9; alu_bank_i = 0; alu_lo_i = 1;
        alu_data_i = 32'hCAFEF00D;
        arb_cycle(ga, gl);
        reset = 1;
        lsu_valid_i = 1;
        #1;
        check("rst_alu_ready", 64'(alu_ready_o), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready_o), 64'd0);
        check("rst_we1_masked", 64'(wp_we1_o), 64'd0);
        tick();
        check("rst2_we1", 64'(wp_we1_o), 64'd0);
        check("rst2_busy", 64'(busy_o), 64'd0);
        check("rst2_addr", 64'(wp_addr_o), 64'd0);
        check("rst2_data", 64'(wp_data_o), 64'd0);
        reset = 0;
        alu_valid_i = 0;
        lsu_valid_i = 0;
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
